// File: rtl/pila_trig_if.sv
// Signal bundle between the J1-side controller and pila_trig.
// arm_i/abort_i are single-cycle requests; capture_o is a write strobe with no back-pressure.
interface pila_trig_if #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16,
  parameter int DIV_WIDTH = 8
);
  logic                 arm_i;
  logic                 abort_i;
  logic [WIDTH-1:0]     trig_mask_i;
  logic [WIDTH-1:0]     trig_value_i;
  logic                 edge_en_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic [CNT_WIDTH-1:0] count_i;
  logic [WIDTH-1:0]     probe_i;
  logic                 capture_o;
  logic [WIDTH-1:0]     data_o;
  logic                 buf_rst_o;
  logic [1:0]           state_o;
  logic                 done_o;
  logic [CNT_WIDTH-1:0] sample_count_o;

  modport master (
    output arm_i, abort_i, trig_mask_i, trig_value_i, edge_en_i, div_i, count_i, probe_i,
    input  capture_o, data_o, buf_rst_o, state_o, done_o, sample_count_o
  );

  modport slave (
    input  arm_i, abort_i, trig_mask_i, trig_value_i, edge_en_i, div_i, count_i, probe_i,
    output capture_o, data_o, buf_rst_o, state_o, done_o, sample_count_o
  );
endinterface

// File: rtl/pila_trig.sv
// Trigger and sample-rate controller feeding the pila capture buffer:
// waits for a masked probe match, then emits count capture strobes every div+1 cycles.
module pila_trig #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16,
  parameter int DIV_WIDTH = 8
) (
  input logic        cap_clk,
  input logic        rst_n,
  pila_trig_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic                 edge_en_q, edge_en_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic                 prev_match_q, prev_match_d;
  logic                 capture_q, capture_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 buf_rst_q, buf_rst_d;

  logic strobe;
  logic match;
  logic trigger;
  logic do_capture;

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    value_d      = value_q;
    edge_en_d    = edge_en_q;
    div_d        = div_q;
    div_cnt_d    = div_cnt_q;
    count_d      = count_q;
    remaining_d  = remaining_q;
    sample_cnt_d = sample_cnt_q;
    prev_match_d = prev_match_q;
    data_d       = data_q;
    capture_d    = 1'b0;
    buf_rst_d    = 1'b0;
    do_capture   = 1'b0;
    trigger      = 1'b0;

    strobe = ((state_q == S_ARMED) || (state_q == S_CAPTURE)) && (div_cnt_q == '0);
    match  = ((bus.probe_i ^ value_q) & mask_q) == '0;

    if (bus.abort_i) begin
      // Abort beats everything, including a same-cycle arm; the sample count is kept for software.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.arm_i) begin
            mask_d       = bus.trig_mask_i;
            value_d      = bus.trig_value_i;
            edge_en_d    = bus.edge_en_i;
            div_d        = bus.div_i;
            count_d      = (bus.count_i == '0) ? CNT_WIDTH'(1) : bus.count_i;
            sample_cnt_d = '0;
            prev_match_d = 1'b1;
            div_cnt_d    = '0;
            buf_rst_d    = 1'b1;
            state_d      = S_ARMED;
          end
        end
        S_ARMED: begin
          div_cnt_d = strobe ? div_q : div_cnt_q - DIV_WIDTH'(1);
          if (strobe) begin
            // prev_match starts at 1 so an already-matching probe cannot fire an edge trigger.
            trigger      = edge_en_q ? (match && !prev_match_q) : match;
            prev_match_d = match;
            if (trigger) begin
              do_capture  = 1'b1;
              remaining_d = count_q - CNT_WIDTH'(1);
              state_d     = (count_q == CNT_WIDTH'(1)) ? S_DONE : S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          div_cnt_d = strobe ? div_q : div_cnt_q - DIV_WIDTH'(1);
          if (strobe) begin
            do_capture  = 1'b1;
            remaining_d = remaining_q - CNT_WIDTH'(1);
            if (remaining_q == CNT_WIDTH'(1)) begin
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (do_capture) begin
      capture_d    = 1'b1;
      data_d       = bus.probe_i;
      sample_cnt_d = (sample_cnt_q == '1) ? sample_cnt_q : sample_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge cap_clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      value_q      <= '0;
      edge_en_q    <= 1'b0;
      div_q        <= '0;
      div_cnt_q    <= '0;
      count_q      <= '0;
      remaining_q  <= '0;
      sample_cnt_q <= '0;
      prev_match_q <= 1'b0;
      capture_q    <= 1'b0;
      data_q       <= '0;
      buf_rst_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      value_q      <= value_d;
      edge_en_q    <= edge_en_d;
      div_q        <= div_d;
      div_cnt_q    <= div_cnt_d;
      count_q      <= count_d;
      remaining_q  <= remaining_d;
      sample_cnt_q <= sample_cnt_d;
      prev_match_q <= prev_match_d;
      capture_q    <= capture_d;
      data_q       <= data_d;
      buf_rst_q    <= buf_rst_d;
    end
  end

  assign bus.capture_o      = capture_q;
  assign bus.data_o         = data_q;
  assign bus.buf_rst_o      = buf_rst_q;
  assign bus.state_o        = state_q;
  assign bus.done_o         = (state_q == S_DONE);
  assign bus.sample_count_o = sample_cnt_q;

endmodule

// File: tb/tb_pila_trig.sv
// Directed bench for pila_trig: hand-computed expectations checked with immediate assertions.
module tb_pila_trig;

  logic cap_clk;
  logic rst_n;

  pila_trig_if #(.WIDTH(16), .CNT_WIDTH(16), .DIV_WIDTH(8)) bus ();

  pila_trig #(.WIDTH(16), .CNT_WIDTH(16), .DIV_WIDTH(8)) dut (
    .cap_clk (cap_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // clock / reset
  initial cap_clk = 1'b0;
  always #5 cap_clk = ~cap_clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_buf_rst = 0;
  logic [15:0] cap_q[$];
  logic [15:0] exp_q[$];

  // record strobes on the falling edge, away from the active edge
  always @(negedge cap_clk) begin
    if (bus.capture_o === 1'b1) cap_q.push_back(bus.data_o);
    if (bus.buf_rst_o === 1'b1) n_buf_rst++;
  end

  task automatic tick();
    @(posedge cap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic arm(input logic [15:0] mask, input logic [15:0] value, input logic edge_en,
                     input logic [7:0] div, input logic [15:0] count);
    bus.trig_mask_i  = mask;
    bus.trig_value_i = value;
    bus.edge_en_i    = edge_en;
    bus.div_i        = div;
    bus.count_i      = count;
    bus.arm_i        = 1'b1;
    tick();
    bus.arm_i        = 1'b0;
  endtask

  task automatic clear_log();
    cap_q.delete();
    exp_q.delete();
    n_buf_rst = 0;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_ncap"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk($sformatf("%s_data%0d", tag, i), cap_q[i], exp_q[i]);
  endtask

  logic [15:0] seq1 [7];
  logic [12:0] hits;

  initial begin
    rst_n            = 1'b0;
    bus.arm_i        = 1'b0;
    bus.abort_i      = 1'b0;
    bus.trig_mask_i  = '0;
    bus.trig_value_i = '0;
    bus.edge_en_i    = 1'b0;
    bus.div_i        = '0;
    bus.count_i      = '0;
    bus.probe_i      = '0;

    // reset values
    tick();
    tick();
    chk("rst_state", bus.state_o, 0);
    chk("rst_capture", bus.capture_o, 0);
    chk("rst_buf_rst", bus.buf_rst_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_count", bus.sample_count_o, 0);
    rst_n = 1'b1;
    tick();

    // level trigger, div=0, count=4
    clear_log();
    bus.probe_i = 16'h0000;
    arm(16'h00FF, 16'h0012, 1'b0, 8'd0, 16'd4);
    chk("t1_armed", bus.state_o, 1);
    chk("t1_buf_rst", bus.buf_rst_o, 1);
    seq1 = '{16'h0000, 16'h0000, 16'h0000, 16'hAB12, 16'h0001, 16'h0002, 16'h0003};
    for (int i = 0; i < 7; i++) begin
      bus.probe_i = seq1[i];
      tick();
      if (i == 2) chk("t1_no_early_cap", cap_q.size(), 0);
    end
    chk("t1_state_done", bus.state_o, 3);
    chk("t1_done", bus.done_o, 1);
    chk("t1_count", bus.sample_count_o, 4);
    tick();
    chk("t1_cap_low", bus.capture_o, 0);
    chk("t1_nbufrst", n_buf_rst, 1);
    exp_q.push_back(16'hAB12);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0003);
    check_log("t1");

    // edge trigger; arm in ARMED and config changes are ignored
    clear_log();
    bus.probe_i = 16'h0012;
    arm(16'h00FF, 16'h0012, 1'b1, 8'd0, 16'd1);
    tick();
    bus.arm_i        = 1'b1;
    bus.trig_value_i = 16'hFFFF;
    tick();
    bus.arm_i = 1'b0;
    chk("t2_arm_ignored_bufrst", bus.buf_rst_o, 0);
    chk("t2_arm_ignored_state", bus.state_o, 1);
    tick();
    chk("t2_no_level_cap", cap_q.size(), 0);
    bus.probe_i = 16'h0013;
    tick();
    chk("t2_still_armed", bus.state_o, 1);
    bus.probe_i = 16'h5512;
    tick();
    chk("t2_state_done", bus.state_o, 3);
    chk("t2_capture", bus.capture_o, 1);
    chk("t2_data", bus.data_o, 16'h5512);
    chk("t2_count", bus.sample_count_o, 1);
    chk("t2_nbufrst", n_buf_rst, 1);

    // div=3, count=3, mask=0: strobes at ARMED entry +1, +5, +9
    clear_log();
    bus.probe_i = 16'h1234;
    arm(16'h0000, 16'h0000, 1'b0, 8'd3, 16'd3);
    hits = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      hits[i] = bus.capture_o;
    end
    chk("t3_hit_pattern", hits, 13'h0222);
    chk("t3_state_done", bus.state_o, 3);
    chk("t3_count", bus.sample_count_o, 3);

    // count=0 behaves as 1
    clear_log();
    bus.probe_i = 16'h00C0;
    arm(16'h0000, 16'h0000, 1'b0, 8'd0, 16'd0);
    tick();
    chk("t4_state_done", bus.state_o, 3);
    tick();
    tick();
    chk("t4_count", bus.sample_count_o, 1);
    exp_q.push_back(16'h00C0);
    check_log("t4");

    // abort in CAPTURE after 2 of 10
    clear_log();
    bus.probe_i = 16'h0077;
    arm(16'h0000, 16'h0000, 1'b0, 8'd0, 16'd10);
    tick();
    tick();
    chk("t5_capturing", bus.state_o, 2);
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    chk("t5_abort_state", bus.state_o, 0);
    chk("t5_abort_nocap", bus.capture_o, 0);
    tick();
    tick();
    chk("t5_count_held", bus.sample_count_o, 2);
    chk("t5_ncap", cap_q.size(), 2);

    // arm + abort together in DONE
    arm(16'h0000, 16'h0000, 1'b0, 8'd0, 16'd1);
    tick();
    chk("t5_done", bus.state_o, 3);
    n_buf_rst   = 0;
    bus.arm_i   = 1'b1;
    bus.abort_i = 1'b1;
    tick();
    bus.arm_i   = 1'b0;
    bus.abort_i = 1'b0;
    chk("t5_armabort_state", bus.state_o, 0);
    chk("t5_armabort_bufrst", bus.buf_rst_o, 0);
    tick();
    chk("t5_armabort_nbufrst", n_buf_rst, 0);

    // reset mid-CAPTURE
    clear_log();
    bus.probe_i = 16'hBEEF;
    arm(16'h0000, 16'h0000, 1'b0, 8'd0, 16'd10);
    tick();
    tick();
    chk("t6_capturing", bus.state_o, 2);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_state", bus.state_o, 0);
    chk("t6_rst_capture", bus.capture_o, 0);
    chk("t6_rst_data", bus.data_o, 0);
    chk("t6_rst_count", bus.sample_count_o, 0);
    chk("t6_rst_done", bus.done_o, 0);
    chk("t6_rst_bufrst", bus.buf_rst_o, 0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_ncap", cap_q.size(), 2);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pila_trig.md
Name: pila_trig

Overview:
- Trigger and sample-rate controller directly upstream of the pila capture buffer.
- Watches a probe bus, waits for a masked pattern match (level or rising-edge of match), then issues a programmed number of capture strobes at a divided sample rate.
- Outputs are registered and feed pila's capture_i, data_i and rst.
- Software on the J1 side arms the block, polls state_o, and then reads the buffer out.

Parameters:
- WIDTH, 16, probe/data bus width; must equal pila WIDTH.
- CNT_WIDTH, 16, width of the post-trigger sample count and the sample counter.
- DIV_WIDTH, 8, width of the sample-rate divider.

Ports:
- cap_clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous, active-low reset.
- arm_i  in  1  one-cycle arm request.
- abort_i  in  1  one-cycle abort request.
- trig_mask_i  in  WIDTH  1 = bit participates in match.
- trig_value_i  in  WIDTH  required value of masked bits.
- edge_en_i  in  1  0 = level trigger, 1 = trigger only on false->true match transition.
- div_i  in  DIV_WIDTH  sample every div_i+1 cycles.
- count_i  in  CNT_WIDTH  samples to capture, including the trigger sample; 0 is treated as 1.
- probe_i  in  WIDTH  signals under observation, synchronous to cap_clk.
- capture_o  out  1  one-cycle write strobe to pila capture_i.
- data_o  out  WIDTH  sample for pila data_i; valid when capture_o=1.
- buf_rst_o  out  1  one-cycle active-high pulse to pila rst on arm.
- state_o  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- done_o  out  1  high in DONE.
- sample_count_o  out  CNT_WIDTH  capture strobes issued since last arm.

Behaviour:
- Reset (rst_n=0 at a cap_clk edge):
  - state IDLE.
  - capture_o, buf_rst_o, done_o = 0.
  - data_o and sample_count_o = 0.
  - divider and internal latches cleared.
- Arm:
  - Accepted when arm_i=1 in IDLE or DONE. arm_i in ARMED or CAPTURE is ignored.
  - On acceptance:
    - Latch mask, value, edge_en, div and count (count 0 -> 1).
    - Clear sample_count_o; set prev_match=1.
    - Reload divider to 0; next state ARMED.
    - buf_rst_o=1 for exactly the next cycle.
  - Config input changes after arm have no effect until the next arm.
- Abort:
  - abort_i=1 forces IDLE next cycle from any state; no capture_o in that next cycle.
  - abort_i wins over a simultaneous arm_i.
  - sample_count_o holds its value.
- Divider:
  - strobe = (div_cnt==0). On strobe, div_cnt reloads latched div; otherwise it decrements.
  - The divider runs only in ARMED and CAPTURE.
  - The first strobe is the first cycle in ARMED.
- Match: match = (((probe_i ^ value) & mask) == 0), evaluated only on strobe cycles.
  - mask=0 matches on every strobe.
- ARMED, on each strobe:
  - trigger = match if edge_en=0; match & ~prev_match if edge_en=1.
  - prev_match <= match.
  - On trigger:
    - Capture this sample and go to CAPTURE; remaining <= count-1.
    - If count==1, go to DONE instead.
- CAPTURE, on each strobe:
  - Capture the sample and decrement remaining.
  - Go to DONE when the capture with remaining==1 is issued.
- Capture timing: a sample captured at edge N appears as capture_o=1 and data_o=probe_i(N) during cycle N+1 (latency 1). sample_count_o increments in the same cycle.
- capture_o is never high for two consecutive cycles when div>=1. With div=0 it may be high every cycle.
- DONE:
  - done_o=1, no strobes.
  - Stays in DONE until arm_i or abort_i.
- sample_count_o saturates at all-ones.
- Buffer full: the block does not track pila fullness. Extra strobes are dropped by pila.
- Reset asserted mid-capture returns everything to reset values on that edge, with no further strobes.

Test Plan:
- Reset, then arm with mask=0x00FF, value=0x0012, edge_en=0, div=0, count=4. Drive probe 0x0000 for 3 cycles, then 0xAB12, 0x0001, 0x0002, 0x0003. Required response:
  - buf_rst_o pulses once.
  - Exactly 4 capture_o pulses with data 0xAB12, 0x0001, 0x0002, 0x0003.
  - done_o=1 and sample_count_o=4.
- edge_en=1, probe already matching at arm: no trigger. Drop probe to a non-match for one strobe, then restore it: trigger on the restore sample.
- div=3, count=3, mask=0: capture_o pulses on ARMED-entry+1, +5 and +9 cycles, then DONE.
- count=0: exactly one capture, then DONE with sample_count_o=1.
- Abort in CAPTURE after 2 of 10 samples: state IDLE next cycle, no further capture_o, sample_count_o=2. Simultaneous arm_i+abort_i in DONE: IDLE and no buf_rst_o.
- rst_n=0 mid-CAPTURE: all outputs zero on the next cycle. arm_i in ARMED is ignored, with no buf_rst_o pulse.
